// File: rtl/npc_mem_pkg.sv
// Shared types and constants for the NPC memory responder.
// States, reset base address, LFSR seed and tap mask.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;
  localparam logic [15:0] LFSR_SEED        = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS        = 16'hB400;

endpackage

// File: rtl/npc_mem_responder_lfsr.sv
// 16-bit Fibonacci LFSR used to jitter response latency.
// Only instantiated when NPC_MEM_RAND_DELAY_EN is defined.
module npc_lfsr16
  import npc_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/npc_mem_responder.sv
// Fixed-latency word memory responder for the NPC LSU port.
// Define NPC_MEM_RAND_DELAY_EN to add 0..7 LFSR-driven wait cycles.
module npc_mem_responder
  import npc_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = MEM_BASE_DEFAULT,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW    = DEPTH_LOG2;
  localparam int WORDS = 1 << AW;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [0:WORDS-1];

  logic        op_wen;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [3:0]  op_wmask;
  logic [31:0] diff;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [31:0] stored;
  logic [31:0] merged;
  logic        enter_resp;
  logic        commit;
  logic [4:0]  extra;
  logic [4:0]  total;

`ifdef NPC_MEM_RAND_DELAY_EN
  logic [15:0] lfsr;

  npc_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr)
  );

  assign extra = {2'b00, lfsr[2:0]};
`else
  assign extra = 5'd0;
`endif

  assign total = 5'(LATENCY) + extra;

  // With zero wait the accept edge is also the commit edge,
  // so the live request fields must feed the datapath.
  always_comb begin
    op_wen   = wen_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_wmask = wmask_q;
    if (state_q == IDLE) begin
      op_wen   = req_wen;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_wmask = req_wmask[3:0];
    end
  end

  assign diff     = op_addr - BASE_ADDR;
  assign in_range = (diff >> (AW + 2)) == 32'd0;
  assign idx      = diff[AW+1:2];
  assign stored   = mem_q[idx];

  always_comb begin
    merged = stored;
    for (int i = 0; i < 4; i++) begin
      if (op_wmask[i]) begin
        merged[8*i +: 8] = op_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask[3:0];
          cnt_d   = total;
          if (total == 5'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      if (in_range) begin
        rdata_d = op_wen ? merged : stored;
        err_d   = 1'b0;
        commit  = op_wen;
      end else begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; a write racing reset is dropped.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      mem_q[idx] <= merged;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  logic unused_bits;
  assign unused_bits = ^{req_wmask[7:4], diff[1:0]};

endmodule

// File: tb/tb_npc_mem_responder.sv
// Directed self-checking bench for npc_mem_responder.
// Default build: LATENCY=2, DEPTH_LOG2=14, base 0x8000_0000.
module tb_npc_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks;
  int fails;

  npc_mem_responder #(
    .DEPTH_LOG2 (14),
    .BASE_ADDR  (32'h8000_0000),
    .LATENCY    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and completes its handshake; no checking here.
  task automatic txn(input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [7:0] wmask,
                     output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      fails++;
      $display("FAIL txn_timeout addr=%h rsp_valid=%b required 1",
               addr, rsp_valid);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags got rdy/vld/err=%b required 100",
               {req_ready, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_rdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_rdata got %h required 0", rsp_rdata);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    logic e;
    txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, d, e);
    checks++;
    if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
      fails++;
      $display("FAIL wr_rsp got %h/%b required deadbeef/0", d, e);
    end
    txn(1'b0, 32'h8000_0010, 32'h0, 8'h0, d, e);
    checks++;
    if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
      fails++;
      $display("FAIL rd_back got %h/%b required deadbeef/0", d, e);
    end
    txn(1'b0, 32'h8000_0013, 32'h0, 8'h0, d, e);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL rd_unaligned got %h required deadbeef", d);
    end
  endtask

  task automatic test_partial_mask();
    logic [31:0] d;
    logic e;
    txn(1'b1, 32'h8000_0020, 32'h1122_3344, 8'h0F, d, e);
    txn(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 8'h05, d, e);
    checks++;
    if (d !== 32'h11BB_33DD || e !== 1'b0) begin
      fails++;
      $display("FAIL mask5_rsp got %h/%b required 11bb33dd/0", d, e);
    end
    txn(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 8'hF0, d, e);
    checks++;
    if (d !== 32'h11BB_33DD || e !== 1'b0) begin
      fails++;
      $display("FAIL mask0_rsp got %h/%b required 11bb33dd/0", d, e);
    end
    txn(1'b0, 32'h8000_0020, 32'h0, 8'h0, d, e);
    checks++;
    if (d !== 32'h11BB_33DD) begin
      fails++;
      $display("FAIL mask_rd got %h required 11bb33dd", d);
    end
  endtask

  task automatic test_latency();
    logic [2:0] obs;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    obs[0] = rsp_valid | req_ready;
    @(negedge clk);
    obs[1] = rsp_valid | req_ready;
    @(negedge clk);
    obs[2] = rsp_valid;
    checks++;
    if (obs !== 3'b100) begin
      fails++;
      $display("FAIL latency got e2/e1/e0=%b required 100", obs);
    end
    checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL latency_data got %h required deadbeef", rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready, rsp_err} !== 3'b010) begin
      fails++;
      $display("FAIL lat_idle got vld/rdy/err=%b required 010",
               {rsp_valid, req_ready, rsp_err});
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    int n;
    logic [31:0] d;
    logic e;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0010;
    @(negedge clk);
    req_wen   = 1'b1;
    req_wdata = 32'h0BAD_0BAD;
    req_wmask = 8'h0F;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid || req_ready || rsp_rdata !== 32'hDEAD_BEEF) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL stall_hold got %0d bad cycles required 0", bad);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      fails++;
      $display("FAIL stall_release got vld/rdy=%b required 01",
               {rsp_valid, req_ready});
    end
    txn(1'b0, 32'h8000_0010, 32'h0, 8'h0, d, e);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL stall_ignored got %h required deadbeef", d);
    end
  endtask

  task automatic test_range();
    logic [31:0] d;
    logic e;
    txn(1'b1, 32'h8000_0000, 32'h0BAD_F00D, 8'h0F, d, e);
    txn(1'b1, 32'h8000_FFFC, 32'h5A5A_A5A5, 8'h0F, d, e);
    checks++;
    if (d !== 32'h5A5A_A5A5 || e !== 1'b0) begin
      fails++;
      $display("FAIL top_word got %h/%b required 5a5aa5a5/0", d, e);
    end
    txn(1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0, d, e);
    checks++;
    if (d !== 32'd0 || e !== 1'b1) begin
      fails++;
      $display("FAIL below_base got %h/%b required 0/1", d, e);
    end
    txn(1'b0, 32'h8001_0000, 32'h0, 8'h0, d, e);
    checks++;
    if (d !== 32'd0 || e !== 1'b1) begin
      fails++;
      $display("FAIL above_top got %h/%b required 0/1", d, e);
    end
    txn(1'b1, 32'h8001_0000, 32'h1111_1111, 8'h0F, d, e);
    txn(1'b1, 32'h7FFF_FFFC, 32'h2222_2222, 8'h0F, d, e);
    checks++;
    if (d !== 32'd0 || e !== 1'b1) begin
      fails++;
      $display("FAIL oor_write got %h/%b required 0/1", d, e);
    end
    txn(1'b0, 32'h8000_0000, 32'h0, 8'h0, d, e);
    checks++;
    if (d !== 32'h0BAD_F00D || e !== 1'b0) begin
      fails++;
      $display("FAIL wrap_lo got %h/%b required 0badf00d/0", d, e);
    end
    txn(1'b0, 32'h8000_FFFC, 32'h0, 8'h0, d, e);
    checks++;
    if (d !== 32'h5A5A_A5A5 || e !== 1'b0) begin
      fails++;
      $display("FAIL wrap_hi got %h/%b required 5a5aa5a5/0", d, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic e;
    txn(1'b1, 32'h8000_0030, 32'h1234_5678, 8'h0F, d, e);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0030;
    req_wdata = 32'hCAFE_F00D;
    req_wmask = 8'h0F;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_wait got req_ready=%b required 0", req_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      fails++;
      $display("FAIL mid_rst got vld/rdy=%b required 01",
               {rsp_valid, req_ready});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 32'h8000_0030, 32'h0, 8'h0, d, e);
    checks++;
    if (d !== 32'h1234_5678 || e !== 1'b0) begin
      fails++;
      $display("FAIL mid_rd got %h/%b required 12345678/0", d, e);
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_wmask = 8'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_write_read();
    test_partial_mask();
    test_latency();
    test_backpressure();
    test_range();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
